// File: rtl/dm_ibp_buf.sv
// Debug-module IBP decoupling buffer: four independent in-order FIFOs
// (command, write data, read response, write response) gated by dm_active.

module dm_ibp_fifo #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_a,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_accept,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_accept,
    output logic [W-1:0] out_data,
    output logic         empty
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;

    // Accept comes from registered occupancy only, so a full FIFO refuses a push even when popping.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_accept = en & ~full;
    assign out_valid = en & ~empty;
    assign push      = in_valid & in_accept;
    assign pop       = out_valid & out_accept;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

module dm_ibp_buf #(
    parameter int unsigned SBA_ADDR_W = 32,
    parameter int unsigned SBA_DATA_W = 64,
    parameter int unsigned CMD_DEPTH  = 2,
    parameter int unsigned WR_DEPTH   = 2,
    parameter int unsigned RD_DEPTH   = 2,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_a,
    input  logic                    dm_active,

    input  logic                    mst_cmd_valid,
    output logic                    slv_cmd_accept,
    input  logic                    mst_cmd_read,
    input  logic [SBA_ADDR_W-1:0]   mst_cmd_addr,
    input  logic [3:0]              mst_cmd_space,
    input  logic [3:0]              mst_cmd_burst,
    output logic                    slv_cmd_valid,
    input  logic                    mst_cmd_accept,
    output logic                    slv_cmd_read,
    output logic [SBA_ADDR_W-1:0]   slv_cmd_addr,
    output logic [3:0]              slv_cmd_space,
    output logic [3:0]              slv_cmd_burst,

    input  logic                    mst_wr_valid,
    output logic                    slv_wr_accept,
    input  logic [SBA_DATA_W-1:0]   mst_wr_data,
    input  logic [SBA_DATA_W/8-1:0] mst_wr_mask,
    input  logic                    mst_wr_last,
    output logic                    slv_wr_valid,
    input  logic                    mst_wr_accept,
    output logic [SBA_DATA_W-1:0]   slv_wr_data,
    output logic [SBA_DATA_W/8-1:0] slv_wr_mask,
    output logic                    slv_wr_last,

    input  logic                    mst_rd_valid,
    output logic                    slv_rd_accept,
    input  logic                    mst_rd_err,
    input  logic [SBA_DATA_W-1:0]   mst_rd_data,
    input  logic                    mst_rd_last,
    output logic                    slv_rd_valid,
    input  logic                    mst_rd_accept,
    output logic                    slv_rd_err,
    output logic [SBA_DATA_W-1:0]   slv_rd_data,
    output logic                    slv_rd_last,

    input  logic                    mst_wr_done,
    input  logic                    mst_wr_err,
    output logic                    slv_wr_resp_accept,
    output logic                    slv_wr_done,
    output logic                    slv_wr_err,
    input  logic                    mst_wr_resp_accept,

    output logic                    ibp_idle
);
    localparam int unsigned MASK_W = SBA_DATA_W / 8;
    localparam int unsigned CMD_W  = 1 + SBA_ADDR_W + 8;
    localparam int unsigned WR_W   = SBA_DATA_W + MASK_W + 1;
    localparam int unsigned RD_W   = 1 + SBA_DATA_W + 1;

    logic [CMD_W-1:0] cmd_out;
    logic [WR_W-1:0]  wr_out;
    logic [RD_W-1:0]  rd_out;
    logic [3:0]       empty;

    dm_ibp_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd (
        .clk(clk), .rst_a(rst_a), .en(dm_active),
        .in_valid(mst_cmd_valid), .in_accept(slv_cmd_accept),
        .in_data({mst_cmd_read, mst_cmd_addr, mst_cmd_space, mst_cmd_burst}),
        .out_valid(slv_cmd_valid), .out_accept(mst_cmd_accept),
        .out_data(cmd_out), .empty(empty[0])
    );

    dm_ibp_fifo #(.W(WR_W), .DEPTH(WR_DEPTH)) u_wr (
        .clk(clk), .rst_a(rst_a), .en(dm_active),
        .in_valid(mst_wr_valid), .in_accept(slv_wr_accept),
        .in_data({mst_wr_data, mst_wr_mask, mst_wr_last}),
        .out_valid(slv_wr_valid), .out_accept(mst_wr_accept),
        .out_data(wr_out), .empty(empty[1])
    );

    dm_ibp_fifo #(.W(RD_W), .DEPTH(RD_DEPTH)) u_rd (
        .clk(clk), .rst_a(rst_a), .en(dm_active),
        .in_valid(mst_rd_valid), .in_accept(slv_rd_accept),
        .in_data({mst_rd_err, mst_rd_data, mst_rd_last}),
        .out_valid(slv_rd_valid), .out_accept(mst_rd_accept),
        .out_data(rd_out), .empty(empty[2])
    );

    // Write response: the done strobe is the valid, the error bit is the whole entry.
    dm_ibp_fifo #(.W(1), .DEPTH(RESP_DEPTH)) u_resp (
        .clk(clk), .rst_a(rst_a), .en(dm_active),
        .in_valid(mst_wr_done), .in_accept(slv_wr_resp_accept),
        .in_data(mst_wr_err),
        .out_valid(slv_wr_done), .out_accept(mst_wr_resp_accept),
        .out_data(slv_wr_err), .empty(empty[3])
    );

    assign {slv_cmd_read, slv_cmd_addr, slv_cmd_space, slv_cmd_burst} = cmd_out;
    assign {slv_wr_data, slv_wr_mask, slv_wr_last}                   = wr_out;
    assign {slv_rd_err, slv_rd_data, slv_rd_last}                    = rd_out;
    assign ibp_idle = &empty;
endmodule

// File: tb/tb_dm_ibp_buf.sv
// Directed scoreboard bench for dm_ibp_buf: driver queues expected entries, a
// negedge monitor pops and compares on every downstream handshake.

module tb_dm_ibp_buf;
    logic        clk = 1'b0;
    logic        rst_a, dm_active;
    logic        mst_cmd_valid, slv_cmd_accept, mst_cmd_read;
    logic [31:0] mst_cmd_addr;
    logic [3:0]  mst_cmd_space, mst_cmd_burst;
    logic        slv_cmd_valid, mst_cmd_accept, slv_cmd_read;
    logic [31:0] slv_cmd_addr;
    logic [3:0]  slv_cmd_space, slv_cmd_burst;
    logic        mst_wr_valid, slv_wr_accept, mst_wr_last;
    logic [63:0] mst_wr_data;
    logic [7:0]  mst_wr_mask;
    logic        slv_wr_valid, mst_wr_accept, slv_wr_last;
    logic [63:0] slv_wr_data;
    logic [7:0]  slv_wr_mask;
    logic        mst_rd_valid, slv_rd_accept, mst_rd_err, mst_rd_last;
    logic [63:0] mst_rd_data;
    logic        slv_rd_valid, mst_rd_accept, slv_rd_err, slv_rd_last;
    logic [63:0] slv_rd_data;
    logic        mst_wr_done, mst_wr_err, slv_wr_resp_accept;
    logic        slv_wr_done, slv_wr_err, mst_wr_resp_accept;
    logic        ibp_idle;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_pops = 0;

    logic [40:0] exp_cmd[$];
    logic [72:0] exp_wr[$];
    logic [65:0] exp_rd[$];
    logic        exp_resp[$];

    dm_ibp_buf #(.RD_DEPTH(3)) dut (
        .clk(clk), .rst_a(rst_a), .dm_active(dm_active),
        .mst_cmd_valid(mst_cmd_valid), .slv_cmd_accept(slv_cmd_accept),
        .mst_cmd_read(mst_cmd_read), .mst_cmd_addr(mst_cmd_addr),
        .mst_cmd_space(mst_cmd_space), .mst_cmd_burst(mst_cmd_burst),
        .slv_cmd_valid(slv_cmd_valid), .mst_cmd_accept(mst_cmd_accept),
        .slv_cmd_read(slv_cmd_read), .slv_cmd_addr(slv_cmd_addr),
        .slv_cmd_space(slv_cmd_space), .slv_cmd_burst(slv_cmd_burst),
        .mst_wr_valid(mst_wr_valid), .slv_wr_accept(slv_wr_accept),
        .mst_wr_data(mst_wr_data), .mst_wr_mask(mst_wr_mask), .mst_wr_last(mst_wr_last),
        .slv_wr_valid(slv_wr_valid), .mst_wr_accept(mst_wr_accept),
        .slv_wr_data(slv_wr_data), .slv_wr_mask(slv_wr_mask), .slv_wr_last(slv_wr_last),
        .mst_rd_valid(mst_rd_valid), .slv_rd_accept(slv_rd_accept),
        .mst_rd_err(mst_rd_err), .mst_rd_data(mst_rd_data), .mst_rd_last(mst_rd_last),
        .slv_rd_valid(slv_rd_valid), .mst_rd_accept(mst_rd_accept),
        .slv_rd_err(slv_rd_err), .slv_rd_data(slv_rd_data), .slv_rd_last(slv_rd_last),
        .mst_wr_done(mst_wr_done), .mst_wr_err(mst_wr_err),
        .slv_wr_resp_accept(slv_wr_resp_accept),
        .slv_wr_done(slv_wr_done), .slv_wr_err(slv_wr_err),
        .mst_wr_resp_accept(mst_wr_resp_accept),
        .ibp_idle(ibp_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream handshake must match the head of its expected queue.
    always @(negedge clk) begin
        if (slv_cmd_valid && mst_cmd_accept) begin
            if (exp_cmd.size() == 0) chk("cmd_extra", 128'(slv_cmd_addr), 128'hDEAD_0000);
            else chk("cmd_pop", 128'({slv_cmd_read, slv_cmd_addr, slv_cmd_space, slv_cmd_burst}),
                     128'(exp_cmd.pop_front()));
        end
        if (slv_wr_valid && mst_wr_accept) begin
            if (exp_wr.size() == 0) chk("wr_extra", 128'(slv_wr_data), 128'hDEAD_0001);
            else chk("wr_pop", 128'({slv_wr_data, slv_wr_mask, slv_wr_last}), 128'(exp_wr.pop_front()));
        end
        if (slv_rd_valid && mst_rd_accept) begin
            rd_pops++;
            if (exp_rd.size() == 0) chk("rd_extra", 128'(slv_rd_data), 128'hDEAD_0002);
            else chk("rd_pop", 128'({slv_rd_err, slv_rd_data, slv_rd_last}), 128'(exp_rd.pop_front()));
        end
        if (slv_wr_done && mst_wr_resp_accept) begin
            if (exp_resp.size() == 0) chk("resp_extra", 128'(slv_wr_err), 128'h2);
            else chk("resp_pop", 128'(slv_wr_err), 128'(exp_resp.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] wd [3];
        logic [7:0]  wm [3];
        int k;
        wd[0] = 64'h1111_0000_0000_0001; wm[0] = 8'h0F;
        wd[1] = 64'h2222_0000_0000_0002; wm[1] = 8'hF0;
        wd[2] = 64'h3333_0000_0000_0003; wm[2] = 8'hFF;

        rst_a = 1'b1; dm_active = 1'b1;
        mst_cmd_valid = 0; mst_cmd_read = 0; mst_cmd_addr = '0; mst_cmd_space = '0; mst_cmd_burst = '0;
        mst_cmd_accept = 1; mst_wr_valid = 0; mst_wr_data = '0; mst_wr_mask = '0; mst_wr_last = 0;
        mst_wr_accept = 1; mst_rd_valid = 0; mst_rd_err = 0; mst_rd_data = '0; mst_rd_last = 0;
        mst_rd_accept = 1; mst_wr_done = 0; mst_wr_err = 0; mst_wr_resp_accept = 1;
        #3;

        // Reset state
        chk("rst_valids", 128'({slv_cmd_valid, slv_wr_valid, slv_rd_valid, slv_wr_done}), 128'h0);
        chk("rst_accepts", 128'({slv_cmd_accept, slv_wr_accept, slv_rd_accept, slv_wr_resp_accept}), 128'hF);
        chk("rst_idle", 128'(ibp_idle), 128'h1);
        chk("rst_payload", 128'({slv_cmd_addr, slv_rd_data}), 128'h0);
        dm_active = 1'b0; #1;
        chk("rst_accept_inactive", 128'(slv_cmd_accept), 128'h0);
        dm_active = 1'b1;
        step(); rst_a = 1'b0; step();

        // Single command: one-cycle latency, idle drops until popped
        mst_cmd_valid = 1; mst_cmd_read = 1; mst_cmd_addr = 32'h1000; mst_cmd_space = 4'h2; mst_cmd_burst = 4'h1;
        exp_cmd.push_back({1'b1, 32'h1000, 4'h2, 4'h1});
        chk("cmd_no_fallthrough", 128'(slv_cmd_valid), 128'h0);
        step();
        mst_cmd_valid = 0;
        chk("cmd_valid_t1", 128'(slv_cmd_valid), 128'h1);
        chk("cmd_addr_t1", 128'({slv_cmd_read, slv_cmd_addr}), 128'h1_0000_1000);
        chk("cmd_idle_busy", 128'(ibp_idle), 128'h0);
        step();
        chk("cmd_idle_after", 128'(ibp_idle), 128'h1);
        chk("cmd_payload_zero", 128'(slv_cmd_addr), 128'h0);

        // Write data backpressure: third beat stalls until downstream accepts
        mst_wr_accept = 0;
        for (int i = 0; i < 3; i++) begin
            mst_wr_valid = 1; mst_wr_data = wd[i]; mst_wr_mask = wm[i]; mst_wr_last = (i == 2);
            exp_wr.push_back({wd[i], wm[i], i == 2});
            if (i < 2) chk("wr_accept_open", 128'(slv_wr_accept), 128'h1);
            k = 0;
            while (!slv_wr_accept && k < 20) begin
                if (k == 0) chk("wr_accept_full", 128'(slv_wr_accept), 128'h0);
                if (k == 2) begin
                    chk("wr_head_stable", 128'({slv_wr_valid, slv_wr_data}), {64'h1, wd[0]});
                    mst_wr_accept = 1;
                end
                step(); k++;
            end
            if (k == 20) chk("wr_accept_timeout", 128'(k), 128'h0);
            step();
        end
        mst_wr_valid = 0;
        repeat (3) step();
        chk("wr_drained", 128'(exp_wr.size()), 128'h0);

        // Read response streaming through a depth-3 FIFO, one beat per cycle
        rd_pops = 0;
        for (int i = 0; i < 20; i++) begin
            mst_rd_valid = 1; mst_rd_err = (i % 5 == 0); mst_rd_data = 64'hA0 + 64'(i); mst_rd_last = (i == 19);
            exp_rd.push_back({i % 5 == 0, 64'hA0 + 64'(i), i == 19});
            if (i == 10) chk("rd_accept_stream", 128'({slv_rd_accept, slv_rd_valid}), 128'h3);
            step();
        end
        mst_rd_valid = 0;
        step();
        chk("rd_throughput", 128'(rd_pops), 128'd20);
        chk("rd_empty", 128'(slv_rd_valid), 128'h0);

        // Full command FIFO: simultaneous pop does not admit a push
        mst_cmd_accept = 0; mst_cmd_read = 0; mst_cmd_space = 4'h0; mst_cmd_burst = 4'h0;
        mst_cmd_valid = 1; mst_cmd_addr = 32'h3000; exp_cmd.push_back({1'b0, 32'h3000, 8'h00});
        step();
        mst_cmd_addr = 32'h3004; exp_cmd.push_back({1'b0, 32'h3004, 8'h00});
        step();
        mst_cmd_addr = 32'h3008;
        chk("cmd_full_accept", 128'(slv_cmd_accept), 128'h0);
        mst_cmd_accept = 1;
        step();
        mst_cmd_valid = 0; mst_cmd_accept = 0;
        chk("cmd_accept_back", 128'(slv_cmd_accept), 128'h1);
        chk("cmd_head_after", 128'(slv_cmd_addr), 128'h3004);
        mst_cmd_accept = 1;
        repeat (3) step();
        chk("cmd_full_idle", 128'(ibp_idle), 128'h1);

        // Freeze with two write responses queued
        mst_wr_resp_accept = 0;
        mst_wr_done = 1; mst_wr_err = 1; exp_resp.push_back(1'b1);
        step();
        mst_wr_err = 0; exp_resp.push_back(1'b0);
        step();
        mst_wr_done = 0;
        chk("resp_queued", 128'({slv_wr_done, slv_wr_err}), 128'h3);
        dm_active = 0; #1;
        chk("frz_valids", 128'({slv_cmd_valid, slv_wr_valid, slv_rd_valid, slv_wr_done, slv_wr_err}), 128'h0);
        chk("frz_accepts", 128'({slv_cmd_accept, slv_wr_accept, slv_rd_accept, slv_wr_resp_accept}), 128'h0);
        chk("frz_idle", 128'(ibp_idle), 128'h0);
        mst_wr_done = 1; mst_wr_err = 1; mst_wr_resp_accept = 1;
        repeat (3) step();
        chk("frz_held", 128'(slv_wr_done), 128'h0);
        mst_wr_done = 0; dm_active = 1; #1;
        chk("resume_head", 128'({slv_wr_done, slv_wr_err}), 128'h3);
        step();
        chk("resume_second", 128'({slv_wr_done, slv_wr_err}), 128'h2);
        step();
        chk("resume_idle", 128'(ibp_idle), 128'h1);

        // Reset with an entry in every FIFO
        mst_cmd_accept = 0; mst_wr_accept = 0; mst_rd_accept = 0; mst_wr_resp_accept = 0;
        mst_cmd_valid = 1; mst_cmd_addr = 32'h4000;
        mst_wr_valid = 1; mst_wr_data = 64'hDEAD;
        mst_rd_valid = 1; mst_rd_data = 64'hBEEF;
        mst_wr_done = 1; mst_wr_err = 1;
        step();
        mst_cmd_valid = 0; mst_wr_valid = 0; mst_rd_valid = 0; mst_wr_done = 0;
        chk("pre_rst_busy", 128'({ibp_idle, slv_cmd_valid, slv_wr_valid, slv_rd_valid, slv_wr_done}), 128'hF);
        #2 rst_a = 1; #1;
        chk("rst_pulse_valids", 128'({slv_cmd_valid, slv_wr_valid, slv_rd_valid, slv_wr_done}), 128'h0);
        chk("rst_pulse_idle", 128'(ibp_idle), 128'h1);
        step(); rst_a = 0;
        mst_cmd_accept = 1; mst_wr_accept = 1; mst_rd_accept = 1; mst_wr_resp_accept = 1;
        mst_cmd_valid = 1; mst_cmd_read = 0; mst_cmd_addr = 32'h2000; mst_cmd_space = 4'h3; mst_cmd_burst = 4'h0;
        exp_cmd.push_back({1'b0, 32'h2000, 4'h3, 4'h0});
        step();
        mst_cmd_valid = 0;
        chk("post_rst_cmd", 128'({slv_cmd_valid, slv_cmd_addr}), 128'h1_0000_2000);
        chk("post_rst_others", 128'({slv_wr_valid, slv_rd_valid, slv_wr_done}), 128'h0);
        repeat (2) step();
        chk("post_rst_idle", 128'(ibp_idle), 128'h1);

        chk("end_cmd_q", 128'(exp_cmd.size()), 128'h0);
        chk("end_wr_q", 128'(exp_wr.size()), 128'h0);
        chk("end_rd_q", 128'(exp_rd.size()), 128'h0);
        chk("end_resp_q", 128'(exp_resp.size()), 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
